// File: rtl/riscv_single_cycle_top.sv
// riscv_single_cycle_top: single-cycle RV32I core with IM/DM word memories.
// Optional feature macro HALT_ON_ECALL_EN: ECALL/EBREAK freeze the core.

module riscv_sc_mem #(
    parameter int memWords = 1024
) (
    input  logic        clk,
    input  logic [29:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = (memWords > 1) ? $clog2(memWords) : 1;

    reg [31:0] mem [0:memWords-1];

    logic          hit;
    logic [AW-1:0] idx;

    assign hit   = ({2'b00, addr} < 32'(memWords));
    assign idx   = addr[AW-1:0];
    assign rdata = hit ? mem[idx] : '0;

    // word write; addresses past the array are dropped
    always_ff @(posedge clk) begin
        if (we && hit) begin
            mem[idx] <= wdata;
        end
    end
endmodule

module riscv_single_cycle_top #(
    parameter int memWords = 1024
) (
    input logic clk,
    input logic rst
);
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_REG  = 7'b0110011;

    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] next_pc;
    logic [31:0] instr;
    logic [31:0] rf [0:31];

    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        alt;

    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic is_lui, is_aui, is_jal, is_jalr;
    logic is_br, is_ld, is_st, is_imm, is_reg;

    logic [31:0] mem_addr;
    logic [4:0]  sh;
    logic [31:0] dm_rdata;
    logic [31:0] dm_wdata;
    logic        dm_we;
    logic        dm_go;
    logic [31:0] ld_sh;
    logic [31:0] ld_val;
    logic        ld_ok;
    logic [31:0] st_base;
    logic [31:0] st_mask;
    logic [31:0] st_word;
    logic        st_ok;
    logic        taken;
    logic        rd_we;
    logic [31:0] rd_val;
    logic        halted;

    function automatic logic [31:0] alu(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [2:0]  f,
        input logic        sub
    );
        logic [31:0] r;
        r = '0;
        case (f)
            3'b000: r = sub ? a - b : a + b;
            3'b001: r = a << b[4:0];
            3'b010: r = {31'b0, $signed(a) < $signed(b)};
            3'b011: r = {31'b0, a < b};
            3'b100: r = a ^ b;
            3'b101: r = sub ? 32'($signed(a) >>> b[4:0])
                            : a >> b[4:0];
            3'b110: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    riscv_sc_mem #(.memWords(memWords)) IM (
        .clk   (clk),
        .addr  (pc[31:2]),
        .we    (1'b0),
        .wdata (32'h0),
        .rdata (instr)
    );

    assign dm_go = dm_we & rst & ~halted;

    riscv_sc_mem #(.memWords(memWords)) DM (
        .clk   (clk),
        .addr  (mem_addr[31:2]),
        .we    (dm_go),
        .wdata (dm_wdata),
        .rdata (dm_rdata)
    );

    assign opc = instr[6:0];
    assign rd  = instr[11:7];
    assign f3  = instr[14:12];
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign alt = instr[30];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    assign is_lui  = (opc == OP_LUI);
    assign is_aui  = (opc == OP_AUI);
    assign is_jal  = (opc == OP_JAL);
    assign is_jalr = (opc == OP_JALR);
    assign is_br   = (opc == OP_BR);
    assign is_ld   = (opc == OP_LD);
    assign is_st   = (opc == OP_ST);
    assign is_imm  = (opc == OP_IMM);
    assign is_reg  = (opc == OP_REG);

    assign rs1v = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rs2v = (rs2 == 5'd0) ? '0 : rf[rs2];
    assign pc4  = pc + 32'd4;

    assign mem_addr = rs1v + (is_st ? imm_s : imm_i);
    assign sh       = {mem_addr[1:0], 3'b000};
    assign ld_sh    = dm_rdata >> sh;

    // branch condition
    always_comb begin
        case (f3)
            3'b000:  taken = (rs1v == rs2v);
            3'b001:  taken = (rs1v != rs2v);
            3'b100:  taken = ($signed(rs1v) < $signed(rs2v));
            3'b101:  taken = ($signed(rs1v) >= $signed(rs2v));
            3'b110:  taken = (rs1v < rs2v);
            3'b111:  taken = (rs1v >= rs2v);
            default: taken = 1'b0;
        endcase
    end

    // load lane extraction; lane 3 halfwords see zero above
    always_comb begin
        ld_ok  = 1'b1;
        ld_val = '0;
        case (f3)
            3'b000:  ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'b010:  ld_val = ld_sh;
            3'b100:  ld_val = {24'b0, ld_sh[7:0]};
            3'b101:  ld_val = {16'b0, ld_sh[15:0]};
            default: ld_ok  = 1'b0;
        endcase
    end

    // store merge into the addressed word
    always_comb begin
        st_ok   = 1'b1;
        st_base = '0;
        case (f3)
            3'b000:  st_base = 32'h0000_00ff;
            3'b001:  st_base = 32'h0000_ffff;
            3'b010:  st_base = 32'hffff_ffff;
            default: st_ok   = 1'b0;
        endcase
        st_mask = st_base << sh;
        st_word = (dm_rdata & ~st_mask) | ((rs2v << sh) & st_mask);
    end

    // main decode: writeback value, store request, next pc
    always_comb begin
        rd_we    = 1'b0;
        rd_val   = '0;
        dm_we    = 1'b0;
        dm_wdata = st_word;
        next_pc  = pc4;
        unique case (1'b1)
            is_lui: begin
                rd_we  = 1'b1;
                rd_val = imm_u;
            end
            is_aui: begin
                rd_we  = 1'b1;
                rd_val = pc + imm_u;
            end
            is_jal: begin
                rd_we   = 1'b1;
                rd_val  = pc4;
                next_pc = pc + imm_j;
            end
            is_jalr: begin
                rd_we   = 1'b1;
                rd_val  = pc4;
                next_pc = (rs1v + imm_i) & ~32'd1;
            end
            is_br: begin
                if (taken) next_pc = pc + imm_b;
            end
            is_ld: begin
                rd_we  = ld_ok;
                rd_val = ld_val;
            end
            is_st: begin
                dm_we = st_ok;
            end
            is_imm: begin
                rd_we  = 1'b1;
                rd_val = alu(rs1v, imm_i, f3,
                             (f3 == 3'b101) & alt);
            end
            is_reg: begin
                rd_we  = 1'b1;
                rd_val = alu(rs1v, rs2v, f3, alt);
            end
            default: begin
            end
        endcase
    end

`ifdef HALT_ON_ECALL_EN
    logic halt_hit;

    assign halt_hit = (instr == 32'h0000_0073) ||
                      (instr == 32'h0010_0073);

    // sticky halt, released only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted <= 1'b0;
        end else if (halt_hit) begin
            halted <= 1'b1;
        end
    end
`else
    assign halted = 1'b0;
`endif

    // pc and register file commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (!halted) begin
            pc <= next_pc;
            if (rd_we && (rd != 5'd0)) begin
                rf[rd] <= rd_val;
            end
        end
    end
endmodule

// File: tb/tb_riscv_single_cycle_top.sv
// tb_riscv_single_cycle_top: instruction-level model vs. the core,
// directed programs followed by random programs.

module tb_riscv_single_cycle_top;
    localparam int MW = 100;

    logic clk;
    logic rst;

    int total;
    int bad;
    int pn;

    logic [31:0] img  [0:MW-1];
    logic [31:0] m_im [0:MW-1];
    logic [31:0] m_dm [0:MW-1];
    logic [31:0] m_x  [0:31];
    logic [31:0] m_pc;
    logic        m_halt;

    riscv_single_cycle_top #(.memWords(MW)) dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] e_i(logic [6:0] op, int rd,
                                        int f3, int rs1, int imm);
        logic [31:0] v, d, f, s;
        v = imm; d = rd; f = f3; s = rs1;
        return {v[11:0], s[4:0], f[2:0], d[4:0], op};
    endfunction

    function automatic logic [31:0] e_r(int f7, int rs2, int rs1,
                                        int f3, int rd);
        logic [31:0] a, b, c, d, e;
        a = f7; b = rs2; c = rs1; d = f3; e = rd;
        return {a[6:0], b[4:0], c[4:0], d[2:0], e[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] e_s(int imm, int rs2, int rs1,
                                        int f3);
        logic [31:0] v, b, c, d;
        v = imm; b = rs2; c = rs1; d = f3;
        return {v[11:5], b[4:0], c[4:0], d[2:0], v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] e_b(int f3, int rs1, int rs2,
                                        int imm);
        logic [31:0] v, b, c, d;
        v = imm; b = rs2; c = rs1; d = f3;
        return {v[12], v[10:5], b[4:0], c[4:0], d[2:0],
                v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] e_u(logic [6:0] op, int rd,
                                        int imm);
        logic [31:0] v, d;
        v = imm; d = rd;
        return {v[19:0], d[4:0], op};
    endfunction

    function automatic logic [31:0] e_j(int rd, int imm);
        logic [31:0] v, d;
        v = imm; d = rd;
        return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return e_i(7'h13, rd, 0, rs1, imm);
    endfunction

    task automatic emit(input logic [31:0] w);
        img[pn] = w;
        pn++;
    endtask

    task automatic clear_img();
        for (int i = 0; i < MW; i++) img[i] = '0;
        pn = 0;
    endtask

    task automatic load_image();
        for (int i = 0; i < MW; i++) begin
            dut.IM.mem[i] = img[i];
            dut.DM.mem[i] = img[i];
            m_im[i] = img[i];
            m_dm[i] = img[i];
        end
    endtask

    task automatic m_reset();
        m_pc = '0;
        m_halt = 1'b0;
        for (int i = 0; i < 32; i++) m_x[i] = '0;
    endtask

    task automatic m_wr(input logic [4:0] rd, input logic [31:0] v);
        if (rd != 0) m_x[rd] = v;
    endtask

    // one architectural instruction, straight from the ISA rules
    task automatic m_step();
        logic [31:0] ins, a, b, ii, si, nx, addr, w, r, t;
        logic [4:0]  rd;
        logic [2:0]  f3;
        int          lane, n;
        logic        tk;
        if (m_halt) return;
        ins = '0;
        if (m_pc[31:2] < MW) ins = m_im[m_pc[31:2]];
        rd = ins[11:7];
        f3 = ins[14:12];
        a  = m_x[ins[19:15]];
        b  = m_x[ins[24:20]];
        ii = {{20{ins[31]}}, ins[31:20]};
        si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        nx = m_pc + 4;
        case (ins[6:0])
            7'h37: m_wr(rd, {ins[31:12], 12'h000});
            7'h17: m_wr(rd, m_pc + {ins[31:12], 12'h000});
            7'h6f: begin
                m_wr(rd, m_pc + 4);
                nx = m_pc + {{11{ins[31]}}, ins[31], ins[19:12],
                             ins[20], ins[30:21], 1'b0};
            end
            7'h67: begin
                t = (a + ii) & 32'hffff_fffe;
                m_wr(rd, m_pc + 4);
                nx = t;
            end
            7'h63: begin
                case (f3)
                    0: tk = a == b;
                    1: tk = a != b;
                    4: tk = $signed(a) < $signed(b);
                    5: tk = $signed(a) >= $signed(b);
                    6: tk = a < b;
                    7: tk = a >= b;
                    default: tk = 1'b0;
                endcase
                if (tk) nx = m_pc + {{19{ins[31]}}, ins[31], ins[7],
                                     ins[30:25], ins[11:8], 1'b0};
            end
            7'h03: begin
                addr = a + ii;
                w = '0;
                if (addr[31:2] < MW) w = m_dm[addr[31:2]];
                w = w >> (8 * addr[1:0]);
                case (f3)
                    0: m_wr(rd, {{24{w[7]}}, w[7:0]});
                    1: m_wr(rd, {{16{w[15]}}, w[15:0]});
                    2: m_wr(rd, w);
                    4: m_wr(rd, w & 32'hff);
                    5: m_wr(rd, w & 32'hffff);
                    default: ;
                endcase
            end
            7'h23: begin
                addr = a + si;
                lane = addr[1:0];
                n = (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 2) ? 4 : 0;
                if (addr[31:2] < MW && n > 0) begin
                    w = m_dm[addr[31:2]];
                    for (int k = 0; k < n; k++)
                        if (lane + k < 4) w[8*(lane+k) +: 8] = b[8*k +: 8];
                    m_dm[addr[31:2]] = w;
                end
            end
            7'h13, 7'h33: begin
                if (ins[6:0] == 7'h13) b = ii;
                case (f3)
                    0: r = (ins[6:0] == 7'h33 && ins[30]) ? a - b : a + b;
                    1: r = a << b[4:0];
                    2: r = ($signed(a) < $signed(b)) ? 1 : 0;
                    3: r = (a < b) ? 1 : 0;
                    4: r = a ^ b;
                    5: r = ins[30] ? 32'($signed(a) >>> b[4:0])
                                   : a >> b[4:0];
                    6: r = a | b;
                    default: r = a & b;
                endcase
                m_wr(rd, r);
            end
`ifdef HALT_ON_ECALL_EN
            7'h73: begin
                if (ins == 32'h73 || ins == 32'h0010_0073) begin
                    m_halt = 1'b1;
                    nx = m_pc;
                end
            end
`endif
            default: ;
        endcase
        m_pc = nx;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            m_step();
        end
        @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        for (int i = 64; i < 80; i++)
            check($sformatf("%s.dm%0d", tag, i), dut.DM.mem[i], m_dm[i]);
        for (int i = 1; i < 32; i++)
            check($sformatf("%s.x%0d", tag, i), dut.rf[i], m_x[i]);
        check({tag, ".pc"}, dut.pc, m_pc);
    endtask

    initial begin
        int k, rd, rs1, rs2, f3, off, sz;
        logic [31:0] imm;
        int lf[5];
        int bf[6];
        lf = '{0, 1, 2, 4, 5};
        bf = '{0, 1, 4, 5, 6, 7};
        total = 0;
        bad = 0;
        rst = 1'b0;

        // ALU and x0
        clear_img();
        emit(addi(1, 0, -5));
        emit(addi(2, 0, 3));
        emit(e_r(0, 2, 1, 0, 3));
        emit(e_s(32'h100, 3, 0, 2));
        emit(addi(0, 0, 7));
        emit(e_s(32'h104, 0, 0, 2));
        emit(e_j(0, 0));
        img[65] = 32'hdead_beef;
        load_image();
        do_reset();
        check("rst.pc", dut.pc, 32'h0);
        check("rst.x3", dut.rf[3], 32'h0);
        run(100);
        check("alu.add", dut.DM.mem[64], 32'hffff_fffe);
        check("alu.x0", dut.DM.mem[65], 32'h0);
        check_state("alu");

        // shift/compare, with a reset mid-run
        clear_img();
        emit(e_u(7'h37, 1, 32'h80000));
        emit(e_i(7'h13, 2, 5, 1, 32'h404));
        emit(e_s(32'h100, 2, 0, 2));
        emit(addi(3, 0, -1));
        emit(addi(4, 0, 1));
        emit(e_r(0, 4, 3, 2, 5));
        emit(e_s(32'h104, 5, 0, 2));
        emit(e_r(0, 4, 3, 3, 6));
        emit(e_s(32'h108, 6, 0, 2));
        emit(e_j(0, 0));
        img[66] = 32'h1234_5678;
        load_image();
        do_reset();
        run(12);
        check("mid.x5", dut.rf[5], 32'h1);
        #2 rst = 1'b0;
        #1;
        check("arst.pc", dut.pc, 32'h0);
        check("arst.x5", dut.rf[5], 32'h0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        run(3);
        check("restart.pc", dut.pc, 32'hc);
        run(97);
        check("sh.srai", dut.DM.mem[64], 32'hf800_0000);
        check("sh.slt", dut.DM.mem[65], 32'h1);
        check("sh.sltu", dut.DM.mem[66], 32'h0);
        check_state("shift");

        // loads/stores, lanes and out-of-range access
        clear_img();
        emit(e_u(7'h37, 1, 32'h11223));
        emit(addi(1, 1, 32'h344));
        emit(e_s(32'h100, 1, 0, 2));
        emit(addi(2, 0, 32'haa));
        emit(e_s(32'h101, 2, 0, 0));
        emit(e_i(7'h03, 3, 0, 0, 32'h101));
        emit(e_s(32'h104, 3, 0, 2));
        emit(e_i(7'h03, 4, 5, 0, 32'h102));
        emit(e_s(32'h108, 4, 0, 2));
        emit(e_i(7'h03, 5, 1, 0, 32'h103));
        emit(e_s(32'h10c, 5, 0, 2));
        emit(addi(6, 0, 400));
        emit(e_s(0, 1, 6, 2));
        emit(addi(7, 0, 5));
        emit(e_i(7'h03, 7, 2, 6, 0));
        emit(e_s(32'h110, 7, 0, 2));
        emit(e_j(0, 0));
        img[68] = 32'h5555_5555;
        load_image();
        do_reset();
        run(100);
        check("ls.sb", dut.DM.mem[64], 32'h1122_aa44);
        check("ls.lb", dut.DM.mem[65], 32'hffff_ffaa);
        check("ls.lhu", dut.DM.mem[66], 32'h0000_1122);
        check("ls.lh3", dut.DM.mem[67], 32'h0000_0011);
        check("ls.oor", dut.DM.mem[68], 32'h0);
        check_state("ldst");

        // control flow
        clear_img();
        emit(addi(1, 0, 1));
        emit(addi(2, 0, 2));
        emit(e_b(1, 1, 2, 8));
        emit(addi(10, 0, 99));
        emit(e_s(32'h100, 10, 0, 2));
        emit(addi(3, 0, -1));
        emit(e_b(4, 3, 1, 8));
        emit(addi(11, 0, 1));
        emit(e_s(32'h104, 11, 0, 2));
        emit(e_b(6, 3, 1, 8));
        emit(addi(12, 0, 1));
        emit(e_s(32'h108, 12, 0, 2));
        emit(e_j(13, 8));
        emit(addi(14, 0, 1));
        emit(e_s(32'h10c, 13, 0, 2));
        emit(addi(15, 0, 32'h45));
        emit(e_i(7'h67, 16, 0, 15, 0));
        emit(e_s(32'h110, 16, 0, 2));
        emit(e_s(32'h114, 14, 0, 2));
        emit(e_j(0, 0));
        img[64] = 32'h7777_7777;
        img[65] = 32'h6666_6666;
        img[69] = 32'h4444_4444;
        load_image();
        do_reset();
        run(100);
        check("cf.bne", dut.DM.mem[64], 32'h0);
        check("cf.blt", dut.DM.mem[65], 32'h0);
        check("cf.bltu", dut.DM.mem[66], 32'h1);
        check("cf.jal", dut.DM.mem[67], 32'h34);
        check("cf.jalr", dut.DM.mem[68], 32'h44);
        check("cf.skip", dut.DM.mem[69], 32'h0);
        check_state("ctrl");

        // fetch past the end of IM executes as NOPs
        clear_img();
        emit(addi(1, 0, 400));
        emit(e_s(32'h100, 1, 0, 2));
        emit(e_i(7'h67, 0, 0, 1, 0));
        load_image();
        do_reset();
        run(20);
        check("oor.pc", dut.pc, 32'd468);
        check_state("oorpc");

        // random programs
        for (int p = 0; p < 8; p++) begin
            clear_img();
            for (int i = 0; i < 40; i++) begin
                k   = $urandom_range(0, 9);
                rd  = $urandom_range(0, 7);
                rs1 = $urandom_range(0, 7);
                rs2 = $urandom_range(0, 7);
                f3  = $urandom_range(0, 7);
                case (k)
                    0, 1, 2: begin
                        imm = $urandom_range(0, 4095);
                        if (f3 == 1) imm = imm & 32'h1f;
                        if (f3 == 5) imm = imm & 32'h41f;
                        emit(e_i(7'h13, rd, f3, rs1, imm));
                    end
                    3, 4: begin
                        emit(e_r(((f3 == 0 || f3 == 5) &&
                                  $urandom_range(0, 1) == 1) ? 32 : 0,
                                 rs2, rs1, f3, rd));
                    end
                    5: emit(e_u($urandom_range(0, 1) ? 7'h37 : 7'h17,
                                rd, $urandom()));
                    6: begin
                        sz  = $urandom_range(0, 2);
                        off = 256 + 4 * $urandom_range(0, 15);
                        if (sz != 2) off += $urandom_range(0, 3);
                        emit(e_s(off, rs2, 0, sz));
                    end
                    7: begin
                        f3  = lf[$urandom_range(0, 4)];
                        off = 256 + 4 * $urandom_range(0, 15);
                        if (f3 != 2) off += $urandom_range(0, 3);
                        emit(e_i(7'h03, rd, f3, 0, off));
                    end
                    8: emit(e_b(bf[$urandom_range(0, 5)], rs1, rs2,
                                $urandom_range(0, 1) ? 8 : 12));
                    default: emit(e_j(rd, 8));
                endcase
            end
            emit(e_j(0, 0));
            emit(e_j(0, 0));
            emit(e_j(0, 0));
            for (int i = 64; i < 80; i++) img[i] = $urandom();
            load_image();
            do_reset();
            run(60);
            check_state($sformatf("rnd%0d", p));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
